// File: rtl/mul_sequencer.sv
// mul_sequencer: radix-2 shift-add MUL/MLA controller that borrows the shared ALU for one ADD per multiplier bit.
// Optional MUL_EARLY_TERM_EN finishes as soon as no multiplier bits remain.
module mul_sequencer #(
    parameter logic [3:0] ADD_CMD = 4'b0010,
    parameter int         ITER    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        accumulate,
    input  logic        set_flags,
    input  logic        abort,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] acc_in,
    input  logic [3:0]  sr_in,
    input  logic [31:0] alu_result,
    output logic        alu_req,
    output logic [31:0] alu_val_1,
    output logic [31:0] alu_val_2,
    output logic [3:0]  alu_exe_cmd,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  sr_out,
    output logic        sr_we
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   p, m, q;
    logic [CW-1:0] count;
    logic          sf_l, c_l, v_l, last, go;
    logic          unused_sr;

    assign unused_sr = ^{sr_in[3], sr_in[1]};
    assign go = state == IDLE && start && !abort;

`ifdef MUL_EARLY_TERM_EN
    assign last = q[31:1] == 31'd0 || count == CW'(ITER - 1);
`else
    assign last = count == CW'(ITER - 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        alu_req     = 1'b0;
        stall       = 1'b0;
        done        = 1'b0;
        sr_we       = 1'b0;
        alu_val_1   = 32'd0;
        alu_val_2   = 32'd0;
        alu_exe_cmd = 4'b0000;
        case (state)
            IDLE: state_nx = go ? RUN : IDLE;
            RUN: begin
                alu_req     = 1'b1;
                stall       = 1'b1;
                alu_exe_cmd = ADD_CMD;
                alu_val_1   = p;
                alu_val_2   = q[0] ? m : 32'd0;
                state_nx    = abort ? IDLE : last ? DONE : RUN;
            end
            DONE: begin
                done     = 1'b1;
                sr_we    = sf_l && !abort;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // result/sr_out are captured on the final iteration edge so they are valid during DONE and held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= 32'd0;
            m      <= 32'd0;
            q      <= 32'd0;
            count  <= '0;
            result <= 32'd0;
            sr_out <= 4'd0;
            sf_l   <= 1'b0;
            c_l    <= 1'b0;
            v_l    <= 1'b0;
        end else if (go) begin
            p     <= accumulate ? acc_in : 32'd0;
            m     <= op_a;
            q     <= op_b;
            count <= '0;
            sf_l  <= set_flags;
            c_l   <= sr_in[2];
            v_l   <= sr_in[0];
        end else if (state == RUN) begin
            p     <= alu_result;
            m     <= m << 1;
            q     <= q >> 1;
            count <= count + 1'b1;
            if (last && !abort) begin
                result <= alu_result;
                sr_out <= {alu_result == 32'd0, c_l, alu_result[31], v_l};
            end
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed checks of mul_sequencer with the bench acting as the shared ALU.
module tb_mul_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, accumulate = 1'b0, set_flags = 1'b0, abort = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, acc_in = '0;
    logic [3:0]  sr_in = '0;
    logic [31:0] alu_result;
    logic        alu_req, stall, done, sr_we;
    logic [31:0] alu_val_1, alu_val_2, result;
    logic [3:0]  alu_exe_cmd, sr_out;
    int          checks = 0, errors = 0;

    mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate), .set_flags(set_flags),
        .abort(abort), .op_a(op_a), .op_b(op_b), .acc_in(acc_in), .sr_in(sr_in),
        .alu_result(alu_result), .alu_req(alu_req), .alu_val_1(alu_val_1), .alu_val_2(alu_val_2),
        .alu_exe_cmd(alu_exe_cmd), .stall(stall), .done(done), .result(result),
        .sr_out(sr_out), .sr_we(sr_we)
    );

    // only a genuine ADD command yields a sum, so a wrong command corrupts the product
    assign alu_result = alu_exe_cmd == 4'b0010 ? alu_val_1 + alu_val_2 : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [31:0] b);
        int n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`ifndef MUL_EARLY_TERM_EN
        n = 32;
`endif
        return n + 1;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] acc, input logic accum, input logic sf,
                          input logic [3:0] sr, input logic [31:0] exp_res,
                          input logic [3:0] exp_sr, input logic abort_done);
        int lat, stalls, badcmd, exp_lat;
        exp_lat = lat_of(b);
        op_a = a; op_b = b; acc_in = acc; accumulate = accum; set_flags = sf; sr_in = sr;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a = 32'h5555_5555; op_b = 32'hAAAA_AAAA; acc_in = 32'h1111_1111; sr_in = ~sr;
        lat = 1; stalls = 0; badcmd = 0;
        while (!done && lat < 40) begin
            stalls += int'(stall);
            if (alu_exe_cmd !== 4'b0010 || alu_req !== 1'b1) badcmd++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " stall cycles"}, stalls, exp_lat - 1);
        chk({tag, " run cmd"}, badcmd, 0);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " sr_out"}, sr_out, exp_sr);
        chk({tag, " sr_we"}, sr_we, sf);
        chk({tag, " done idle cmd"}, alu_exe_cmd, 4'b0000);
        if (abort_done) begin
            abort = 1'b1;
            #1;
            chk({tag, " sr_we under abort"}, sr_we, 1'b0);
            chk({tag, " done under abort"}, done, 1'b1);
        end
        tick();
        abort = 1'b0;
        chk({tag, " done pulse width"}, done, 1'b0);
        chk({tag, " result held"}, result, exp_res);
        chk({tag, " sr_out held"}, sr_out, exp_sr);
    endtask

    initial begin
        int cnt;
        #1;
        chk("reset done", done, 1'b0);
        chk("reset stall", stall, 1'b0);
        chk("reset alu_req", alu_req, 1'b0);
        chk("reset result", result, 32'd0);
        chk("reset sr_out", sr_out, 4'd0);
        chk("reset cmd", alu_exe_cmd, 4'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        run_op("mul 6x7", 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 4'b0100, 32'd42, 4'b0100, 1'b0);
        run_op("mla wrap", 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b0, 4'b0000, 32'd3, 4'b0000, 1'b0);
        run_op("mul neg", 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0001, 32'h8000_0000, 4'b0011, 1'b0);
        run_op("mul zero", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 4'b0000, 32'd0, 4'b1000, 1'b1);
        run_op("mla b0", 32'h0000_1234, 32'd0, 32'd9, 1'b1, 1'b0, 4'b0000, 32'd9, 4'b0000, 1'b0);
        run_op("mul 7x6", 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0100, 32'd42, 4'b0100, 1'b0);

        op_a = 32'd6; op_b = 32'h8000_0007; accumulate = 1'b0; set_flags = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("pre-reset stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("async reset stall", stall, 1'b0);
        chk("async reset alu_req", alu_req, 1'b0);
        chk("async reset val_1", alu_val_1, 32'd0);
        chk("async reset result", result, 32'd0);
        chk("async reset sr_out", sr_out, 4'd0);
        chk("async reset done", done, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        run_op("mul 3x3", 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, 32'd9, 4'b0000, 1'b0);

        op_a = 32'd11; op_b = 32'h8000_0003; accumulate = 1'b0; set_flags = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre-abort stall", stall, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort stall", stall, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort sr_we", sr_we, 1'b0);
        chk("abort result held", result, 32'd9);
        cnt = 0;
        repeat (40) begin
            cnt += int'(done) + int'(stall) + int'(sr_we);
            tick();
        end
        chk("no queued start", cnt, 0);

        abort = 1'b1;
        start = 1'b1;
        op_a = 32'd4; op_b = 32'd4;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort beats start", stall, 1'b0);

        run_op("mul 2x5", 32'd2, 32'd5, 32'd0, 1'b0, 1'b1, 4'b0000, 32'd10, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller that runs ARM MUL/MLA on the shared 32-bit ALU, using repeated ADD operations (shift-add, radix-2).
- Sits in the EXE stage beside the ALU. While it runs, it owns the ALU operand/command muxes and stalls the pipeline.
- Returns the low 32 bits of the product (plus optional accumulator) and the Z/C/N/V status word in the codebase's {z, c, n, v} order.

Parameters:
- ADD_CMD, 4'b0010, ALU exe_cmd value driven for each iteration
- ITER, 32, maximum number of iterations (one per multiplier bit)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  start request; sampled in IDLE only
- accumulate  in  1  1 = MLA (initial product = acc_in), 0 = MUL (initial product = 0)
- set_flags  in  1  S bit; gates sr_we
- abort  in  1  synchronous flush; return to IDLE without a done pulse
- op_a  in  32  multiplicand (Rm)
- op_b  in  32  multiplier (Rs)
- acc_in  in  32  accumulator (Rn)
- sr_in  in  4  current status {z,c,n,v}; C and V are captured at start
- alu_result  in  32  result from the shared ALU
- alu_req  out  1  high when the sequencer owns the ALU inputs
- alu_val_1  out  32  ALU operand 1 (running product P)
- alu_val_2  out  32  ALU operand 2 (shifted multiplicand, or 0)
- alu_exe_cmd  out  4  ALU command
- stall  out  1  pipeline freeze request
- done  out  1  one-cycle completion pulse
- result  out  32  final product; valid while done=1, held afterwards
- sr_out  out  4  {z,c,n,v} for the product
- sr_we  out  1  status write enable; equals done & set_flags_latched

Behaviour:
- Reset (async, rst=1): state=IDLE; P, M, Q, count, result, sr_out cleared to 0; alu_req, stall, done, sr_we = 0; alu_exe_cmd = 4'b0000.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge -> RUN.
  - Latch M=op_a, Q=op_b, P=(accumulate ? acc_in : 0), count=0, set_flags, sr_in[c], sr_in[v].
  - start while RUN/DONE is ignored and not queued.
- RUN:
  - alu_req=1, stall=1, alu_exe_cmd=ADD_CMD, alu_val_1=P, alu_val_2=(Q[0] ? M : 0).
  - Each edge: P<=alu_result; M<=M<<1; Q<=Q>>1; count<=count+1.
  - All arithmetic is mod 2^32; carries out of bit 31 are discarded.
  - Transition to DONE on the edge that latches iteration count==ITER-1.
  - Latency, no early termination: start edge E0, iterations latched at E1..E32, done high in the cycle after E32 (33 cycles after start), IDLE at E33.
- DONE:
  - alu_req=0, stall=0, done=1, result=P, sr_we=set_flags_latched.
  - sr_out = {P==0, c_latched, P[31], v_latched}.
  - Next edge -> IDLE. result and sr_out hold until the next start.
- Outside RUN: alu_val_1 = alu_val_2 = 0, alu_exe_cmd = 4'b0000.
- abort=1: from RUN or DONE -> IDLE at next edge. A done pulse in progress is still visible that cycle, but sr_we is forced to 0 in that cycle. abort takes priority over the iteration transition.
- abort and start together in IDLE: abort wins; no start.
- rst mid-operation: immediate IDLE; no done, no sr_we.
- op_a=0 or op_b=0: full ITER iterations (unless early termination is enabled); result = accumulator.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: in RUN, transition to DONE on the edge where the shifted multiplier (Q>>1) == 0 or count==ITER-1, whichever comes first.
  - op_b=0 or op_b=1 -> done one cycle after E1 (2-cycle latency).
  - op_b=6 -> iterations latched at E1..E3, done after E3.
- Not defined: fixed ITER iterations, constant 33-cycle latency.

Test Plan:
- MUL 6*7, set_flags=1, sr_in=4'b0100 -> done exactly 33 cycles after start, result=42, sr_out=4'b0100, sr_we=1, stall high for 32 cycles.
- MLA 0xFFFFFFFF*2 + acc 5, set_flags=0 -> result=3 (mod 2^32), sr_we=0, alu_exe_cmd=4'b0010 throughout RUN.
- MUL 0x80000000*1, set_flags=1, sr_in=4'b0001 -> result=0x80000000, sr_out=4'b0011 (N=1, V preserved); MUL 0x10000*0x10000 -> result=0, Z=1.
- Reset asserted mid-RUN at iteration 10 -> all outputs 0 immediately, no done; a new start of 3*3 afterwards -> 9.
- start pulsed again during RUN, then abort at iteration 5 -> second start ignored, IDLE next edge, no done/sr_we; next start of 2*5 -> 10.
- MUL_EARLY_TERM_EN defined: op_b=0 with acc 9 (MLA) -> done 2 cycles after start, result=9; op_b=6, op_a=7 -> done 4 cycles after start, result=42.
